// File: rtl/sb_tx_pkg.sv
// Shared types and constants for the sideband TX FIFO write-side arbiter.
// The optional strict-priority build is selected with SB_TX_ARB_PRIO0_EN.
package sb_tx_pkg;

  localparam int SB_WORD_W = 64;

  typedef enum logic [1:0] {
    SB_ARB_IDLE = 2'd0,
    SB_ARB_HDR  = 2'd1,
    SB_ARB_DATA = 2'd2
  } sb_arb_state_e;

endpackage

// File: rtl/sb_rr_pick.sv
// Combinational round-robin picker: finds the first eligible requester
// after `last`, wrapping from NUM_REQ-1 back to index 0.
module sb_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [PTR_W-1:0]   last,
  output logic               valid,
  output logic [PTR_W-1:0]   idx
);

  logic [NUM_REQ-1:0] eligible;
  logic [PTR_W-1:0]   cand;

  assign eligible = req & ~mask;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    // Offset 1 first, so the previous winner is considered last.
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = PTR_W'((int'(last) + i) % NUM_REQ);
      if (!valid && eligible[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sb_tx_fifo_arbiter.sv
// Round-robin arbiter sharing the sideband TX FIFO write port; 2-word packets
// are atomic. Define SB_TX_ARB_PRIO0_EN to give requester 0 strict priority.
module sb_tx_fifo_arbiter
  import sb_tx_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = SB_WORD_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_two_word,
  input  logic [NUM_REQ*DATA_W-1:0] i_data,
  output logic [NUM_REQ-1:0]        o_gnt,
  input  logic                      i_fifo_full,
  output logic                      o_fifo_write_enable,
  output logic [DATA_W-1:0]         o_fifo_data,
  output logic                      o_busy,
  output logic                      o_abort
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  sb_arb_state_e      state, state_nxt;
  logic [PTR_W-1:0]   sel, sel_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic               two_word_q, two_word_nxt;

  logic               active, owner_req, wr, pkt_done;
  logic [NUM_REQ-1:0] sel_onehot, pick_mask;
  logic [PTR_W-1:0]   pick_last, pick_idx, win_idx;
  logic               pick_valid, win_valid;

  assign sel_onehot = ONE_HOT0 << sel;
  assign active     = (state != SB_ARB_IDLE);
  assign owner_req  = i_req[sel];
  assign wr         = active && owner_req && !i_fifo_full;
  assign pkt_done   = wr && ((state == SB_ARB_DATA) || !two_word_q);

  // The finishing owner is masked so the done-cycle arbitration hands over.
  assign pick_last  = pkt_done ? sel : rr_ptr;

`ifdef SB_TX_ARB_PRIO0_EN
  assign pick_mask  = (pkt_done ? sel_onehot : '0) | ONE_HOT0;
  assign win_valid  = i_req[0] | pick_valid;
  assign win_idx    = i_req[0] ? '0 : pick_idx;
`else
  assign pick_mask  = pkt_done ? sel_onehot : '0;
  assign win_valid  = pick_valid;
  assign win_idx    = pick_idx;
`endif

  sb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req   (i_req),
    .mask  (pick_mask),
    .last  (pick_last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= SB_ARB_IDLE;
      sel        <= '0;
      rr_ptr     <= LAST_IDX;
      two_word_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      rr_ptr     <= rr_ptr_nxt;
      two_word_q <= two_word_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    rr_ptr_nxt   = rr_ptr;
    two_word_nxt = two_word_q;
    case (state)
      SB_ARB_IDLE: begin
        if (win_valid) begin
          state_nxt    = SB_ARB_HDR;
          sel_nxt      = win_idx;
          two_word_nxt = i_two_word[win_idx];
        end
      end
      SB_ARB_HDR, SB_ARB_DATA: begin
        if (!owner_req) begin
          state_nxt  = SB_ARB_IDLE;
          rr_ptr_nxt = sel;
        end else if (wr && !pkt_done) begin
          state_nxt = SB_ARB_DATA;
        end else if (pkt_done) begin
          rr_ptr_nxt = sel;
          if (win_valid) begin
            state_nxt    = SB_ARB_HDR;
            sel_nxt      = win_idx;
            two_word_nxt = i_two_word[win_idx];
          end else begin
            state_nxt = SB_ARB_IDLE;
          end
        end
      end
      default: state_nxt = SB_ARB_IDLE;
    endcase
  end

  always_comb begin
    o_fifo_write_enable = wr;
    o_gnt               = wr ? sel_onehot : '0;
    o_fifo_data         = wr ? i_data[sel*DATA_W +: DATA_W] : '0;
    o_busy              = active;
    o_abort             = active && !owner_req;
  end

endmodule
